// File: rtl/pcileech_ft601_tx_arb.sv
// rtl/pcileech_ft601_tx_arb.sv - three-source round-robin packet arbiter feeding the FT601 TX queue
// Optional mid-packet stall watchdog with filler-word abort: define FT601_TXARB_WATCHDOG_EN.
module pcileech_ft601_tx_arb #(
  parameter int WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src0_data,
  input  logic [31:0] src1_data,
  input  logic [31:0] src2_data,
  input  logic [2:0]  src_valid,
  input  logic [2:0]  src_last,
  output logic [2:0]  src_ready,
  output logic [31:0] ft_din,
  output logic        ft_din_wr_en,
  input  logic        ft_din_req_data,
  output logic        stat_busy,
  output logic [1:0]  stat_grant,
  output logic        stat_abort
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ABORT} state_t;

  state_t      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  grant_q;
  logic [31:0] din_q;
  logic        wr_en_q;
  logic [1:0]  win_d;
  logic [1:0]  c0, c1, c2;
  logic [31:0] sel_data;
  logic        sel_valid;
  logic        sel_last;
  logic        xfer;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Priority order starts at the pointer and wraps modulo 3.
  always_comb begin
    c0 = ptr_q;
    c1 = next_idx(c0);
    c2 = next_idx(c1);
    if (src_valid[c0])      win_d = c0;
    else if (src_valid[c1]) win_d = c1;
    else                    win_d = c2;
  end

  always_comb begin
    sel_data = src0_data;
    case (grant_q)
      2'd1:    sel_data = src1_data;
      2'd2:    sel_data = src2_data;
      default: sel_data = src0_data;
    endcase
  end

  assign sel_valid = src_valid[grant_q];
  assign sel_last  = src_last[grant_q];

  // Ready is combinational so reset can withdraw it in the very cycle it asserts.
  always_comb begin
    src_ready = 3'b000;
    if (!rst && (state_q == S_XFER) && ft_din_req_data) src_ready[grant_q] = 1'b1;
  end

  assign xfer = src_ready[grant_q] && sel_valid;

`ifdef FT601_TXARB_WATCHDOG_EN
  localparam logic [7:0]  WdogLimit  = 8'(WDOG_CYCLES);
  localparam logic [31:0] FillerWord = 32'h6666_5555;
  logic [7:0] wdog_q;
  logic       abort_q;
  assign stat_abort = abort_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign stat_abort  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      grant_q <= 2'd0;
      din_q   <= 32'd0;
      wr_en_q <= 1'b0;
`ifdef FT601_TXARB_WATCHDOG_EN
      wdog_q  <= 8'd0;
      abort_q <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
`ifdef FT601_TXARB_WATCHDOG_EN
      abort_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|src_valid) begin
            grant_q <= win_d;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (xfer) begin
            din_q   <= sel_data;
            wr_en_q <= 1'b1;
`ifdef FT601_TXARB_WATCHDOG_EN
            wdog_q  <= 8'd0;
`endif
            if (sel_last) begin
              state_q <= S_IDLE;
              ptr_q   <= next_idx(grant_q);
            end
          end
`ifdef FT601_TXARB_WATCHDOG_EN
          // Only source starvation counts; a sink stall is not the source's fault.
          else if (!sel_valid && ft_din_req_data) begin
            if (wdog_q + 8'd1 == WdogLimit) begin
              wdog_q  <= 8'd0;
              state_q <= S_ABORT;
            end else begin
              wdog_q  <= wdog_q + 8'd1;
            end
          end
`endif
        end
        S_ABORT: begin
`ifdef FT601_TXARB_WATCHDOG_EN
          if (ft_din_req_data) begin
            din_q   <= FillerWord;
            wr_en_q <= 1'b1;
            abort_q <= 1'b1;
            ptr_q   <= next_idx(grant_q);
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ft_din       = din_q;
  assign ft_din_wr_en = wr_en_q;
  assign stat_busy    = (state_q != S_IDLE);
  assign stat_grant   = grant_q;

endmodule

// File: doc/pcileech_ft601_tx_arb.md
PCILEECH_FT601_TX_ARB -- requirements
Module: pcileech_ft601_tx_arb

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 255, maximum idle cycles allowed mid-packet before abort (8-bit, legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports src0_data / src1_data / src2_data  input  32 each  source data words.
REQ-005 SHALL have port src_valid  input  3  per-source word valid (bit n = source n).
REQ-006 SHALL have port src_last  input  3  per-source last word of packet, qualified by src_valid.
REQ-007 SHALL have port src_ready  output  3  per-source ready; word moves when valid and ready are both high.
REQ-008 SHALL have port ft_din  output  32  word to FT601 TX queue.
REQ-009 SHALL have port ft_din_wr_en  output  1  write strobe to FT601 TX queue.
REQ-010 SHALL have port ft_din_req_data  input  1  FT601 TX queue can accept a word this cycle.
REQ-011 SHALL have port stat_busy  output  1  high while a packet is granted (XFER or ABORT).
REQ-012 SHALL have port stat_grant  output  2  index of current or last granted source.
REQ-013 SHALL have port stat_abort  output  1  one-cycle pulse when the filler word is written.

Function
REQ-014 SHALL implement states IDLE, XFER, ABORT in a registered state machine.
REQ-015 SHALL keep a 2-bit round-robin pointer: source at pointer highest priority, then pointer+1, pointer+2, each mod 3.
REQ-016 SHALL move IDLE->XFER one cycle after any src_valid bit is high, latching the winning index into stat_grant.
REQ-017 SHALL drive src_ready[n] = (state==XFER) && (stat_grant==n) && ft_din_req_data; all other bits low; never high in IDLE or ABORT.
REQ-018 SHALL register each transferred word: ft_din and ft_din_wr_en=1 appear exactly one cycle after the valid&&ready cycle.
REQ-019 SHALL hold ft_din_wr_en low on every cycle not following a transfer or filler write; ft_din holds its last value.
REQ-020 SHALL lock the grant for the whole packet; a higher-priority source cannot preempt mid-packet.
REQ-021 SHALL, on a transfer with src_last high, return to IDLE and set pointer to (grant+1) mod 3.
REQ-022 SHALL allow back-to-back packets: earliest next grant is the cycle after IDLE is reached (one-cycle gap minimum).
REQ-023 SHALL treat single-word packets (valid and last together on first word) as complete packets.
REQ-024 SHALL never write while ft_din_req_data is low; stalls extend XFER indefinitely without watchdog counting.

Reset
REQ-025 SHALL on rst: state IDLE, pointer 0, stat_grant 0, ft_din 0, ft_din_wr_en 0, stat_busy 0, stat_abort 0, watchdog 0.
REQ-026 SHALL, when rst asserts mid-packet, drop the packet with no further writes and force src_ready to 0 in that same cycle.

Configuration
REQ-027 SHALL compile the watchdog in only when macro FT601_TXARB_WATCHDOG_EN is defined.
REQ-028 SHALL with the macro: in XFER, increment an 8-bit counter each cycle where the granted src_valid is low and ft_din_req_data is high; clear it on any transfer; on reaching WDOG_CYCLES enter ABORT.
REQ-029 SHALL in ABORT: wait for ft_din_req_data, write filler 0x66665555, pulse stat_abort with the write, advance pointer to grant+1 mod 3, return to IDLE; the aborted source's remaining words are then treated as a new packet.
REQ-030 SHALL without the macro: no counter, ABORT unreachable, stat_abort tied 0.

Verification
REQ-031 SHALL verify: all three sources valid with 2-word packets after reset, req_data high -> output order src0,src1,src2, each word on ft_din one cycle after its handshake.
REQ-032 SHALL verify: src1 sends 4-word packet, src0 raises valid after word 1 -> src1's 4 words contiguous, then src0 granted, pointer ends at 1.
REQ-033 SHALL verify: ft_din_req_data low for 10 cycles mid-packet -> src_ready low, no writes, no abort, packet resumes intact.
REQ-034 SHALL verify (macro on, WDOG_CYCLES=4): src2 stalls valid after word 1 -> after 4 idle cycles one write of 0x66665555 with stat_abort pulse, state IDLE, pointer 0.
REQ-035 SHALL verify: rst asserted mid-packet on src0 -> next cycle ft_din_wr_en 0, src_ready 0, stat_busy 0, pointer 0.
